// File: rtl/instr_encoder_pkg.sv
// Shared opcodes, descriptor kinds and FSM states for the instruction-memory loader.
// Opcode values match the main decoder so loaded programs execute unchanged.
package instr_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_LI    = 6'b010001;
  localparam logic [5:0] OP_STOP  = 6'b111111;

  localparam logic [31:0] STOP_WORD = {OP_STOP, 26'd0};

  typedef enum logic [2:0] {
    KIND_RTYPE = 3'd0,
    KIND_LW    = 3'd1,
    KIND_SW    = 3'd2,
    KIND_BEQ   = 3'd3,
    KIND_ADDI  = 3'd4,
    KIND_J     = 3'd5,
    KIND_LI    = 3'd6,
    KIND_RSVD  = 3'd7
  } kind_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_TERM  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // I-format layout shared by loads, stores, branches and immediates.
  function automatic logic [31:0] packImm(
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [15:0] imm
  );
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Descriptor handshake from the boot source plus the imem write port of the loader.
interface instr_encoder_if #(
  parameter int AW = 6
);

  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_kind;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [4:0]    in_shamt;
  logic [5:0]    in_funct;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          finish;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct,
           in_imm, in_target, finish,
    input  in_ready, we, waddr, wdata
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct,
           in_imm, in_target, finish,
    output in_ready, we, waddr, wdata
  );

endinterface

// File: rtl/instr_encoder_fields.sv
// Combinational encoder: descriptor kind plus register/immediate fields to a 32-bit word.
module instr_fields_enc
  import instr_pkg::*;
(
  input  kind_t       kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = 32'd0;
    illegal_o = 1'b0;
    case (kind_i)
      KIND_RTYPE: word_o = {OP_RTYPE, rs_i, rt_i, rd_i, shamt_i, funct_i};
      KIND_LW:    word_o = packImm(OP_LW, rs_i, rt_i, imm_i);
      KIND_SW:    word_o = packImm(OP_SW, rs_i, rt_i, imm_i);
      KIND_BEQ:   word_o = packImm(OP_BEQ, rs_i, rt_i, imm_i);
      KIND_ADDI:  word_o = packImm(OP_ADDI, rs_i, rt_i, imm_i);
      KIND_J:     word_o = {OP_J, target_i};
      // LI has no source operand, so the rs slot is forced to zero.
      KIND_LI:    word_o = packImm(OP_LI, 5'd0, rt_i, imm_i);
      KIND_RSVD:  illegal_o = 1'b1;
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction-memory loader: accepts field-wise descriptors, encodes them and writes
// them sequentially into imem, closing the program with a STOP word.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  instr_encoder_if.slave bus,
  output logic [AW:0]   count,
  output logic          full,
  output logic          done,
  output logic          err_illegal
);

  localparam logic [AW:0] LAST_SLOT = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] COUNT_ONE = (AW+1)'(1);

  state_t        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          errIllegal_q, errIllegal_d;
  logic          finishPending_q, finishPending_d;

  logic [31:0]   encWord;
  logic          encIllegal;
  logic          isFull;
  logic          inReady;
  logic          handshake;

  instr_fields_enc u_fields (
    .kind_i    (kind_t'(bus.in_kind)),
    .rs_i      (bus.in_rs),
    .rt_i      (bus.in_rt),
    .rd_i      (bus.in_rd),
    .shamt_i   (bus.in_shamt),
    .funct_i   (bus.in_funct),
    .imm_i     (bus.in_imm),
    .target_i  (bus.in_target),
    .word_o    (encWord),
    .illegal_o (encIllegal)
  );

  // The last slot is kept for STOP, so descriptors stall once only it remains.
  assign isFull    = (count_q == LAST_SLOT);
  assign inReady   = (state_q == ST_IDLE) && !isFull && !finishPending_q;
  assign handshake = bus.in_valid && inReady;

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    waddr_d         = waddr_q;
    wdata_d         = wdata_q;
    errIllegal_d    = errIllegal_q;
    finishPending_d = finishPending_q;

    if (clear) begin
      state_d         = ST_IDLE;
      count_d         = '0;
      waddr_d         = '0;
      errIllegal_d    = 1'b0;
      finishPending_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (handshake) begin
            if (encIllegal) begin
              errIllegal_d = 1'b1;
            end else begin
              wdata_d = encWord;
              waddr_d = count_q[AW-1:0];
              state_d = ST_WRITE;
            end
            // A finish arriving with a descriptor is deferred until that word lands.
            if (bus.finish) begin
              finishPending_d = 1'b1;
            end
          end else if (bus.finish || finishPending_q) begin
            wdata_d         = STOP_WORD;
            waddr_d         = count_q[AW-1:0];
            finishPending_d = 1'b0;
            state_d         = ST_TERM;
          end
        end
        ST_WRITE: begin
          count_d = count_q + COUNT_ONE;
          state_d = ST_IDLE;
        end
        ST_TERM: begin
          count_d = count_q + COUNT_ONE;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      count_q         <= '0;
      waddr_q         <= '0;
      wdata_q         <= '0;
      errIllegal_q    <= 1'b0;
      finishPending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      waddr_q         <= waddr_d;
      wdata_q         <= wdata_d;
      errIllegal_q    <= errIllegal_d;
      finishPending_q <= finishPending_d;
    end
  end

  // The write strobe follows the state directly so reset and clear kill it in the same cycle.
  assign bus.we       = ((state_q == ST_WRITE) || (state_q == ST_TERM)) && !clear;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign bus.in_ready = inReady;

  assign count       = count_q;
  assign full        = isFull;
  assign done        = (state_q == ST_DONE);
  assign err_illegal = errIllegal_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a transaction-level write predictor.
// A small imem (DEPTH=4) makes the full/STOP-slot corner reachable quickly.
module tb_instr_encoder;
  import instr_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam logic [31:0] STOP_REF = 32'hFC000000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          clear;
  logic [AW:0]   count;
  logic          full;
  logic          done;
  logic          err_illegal;

  instr_encoder_if #(.AW(AW)) bus ();

  instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .bus         (bus),
    .count       (count),
    .full        (full),
    .done        (done),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  int  total = 0;
  int  bad   = 0;
  wr_t expQ[$];
  int  modelNext  = 0;
  bit  modelErr   = 1'b0;
  bit  stopQueued = 1'b0;
  int  written    = 0;
  bit  doneExp    = 1'b0;

  // Reference encoding straight from the field layout rules, built arithmetically.
  function automatic logic [31:0] encodeRef(input int kind, input int rs, input int rt,
                                            input int rd, input int sh, input int fn,
                                            input int imm, input int tgt);
    logic [31:0] op;
    logic [31:0] w;
    case (kind)
      0:       op = 32'd0;
      1:       op = 32'd35;
      2:       op = 32'd43;
      3:       op = 32'd4;
      4:       op = 32'd8;
      5:       op = 32'd2;
      6:       op = 32'd17;
      default: op = 32'd0;
    endcase
    if (kind == 0)
      w = (op << 26) + (32'(rs) << 21) + (32'(rt) << 16) + (32'(rd) << 11) + (32'(sh) << 6) + 32'(fn);
    else if (kind == 5)
      w = (op << 26) + 32'(tgt);
    else if (kind == 6)
      w = (op << 26) + (32'(rt) << 16) + 32'(imm);
    else
      w = (op << 26) + (32'(rs) << 21) + (32'(rt) << 16) + 32'(imm);
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic driveIdle();
    bus.in_valid  = 1'b0;
    bus.in_kind   = 3'd0;
    bus.in_rs     = 5'd0;
    bus.in_rt     = 5'd0;
    bus.in_rd     = 5'd0;
    bus.in_shamt  = 5'd0;
    bus.in_funct  = 6'd0;
    bus.in_imm    = 16'd0;
    bus.in_target = 26'd0;
    bus.finish    = 1'b0;
  endtask

  task automatic modelAccept(input int k, input int rs, input int rt, input int rd, input int sh,
                             input int fn, input int imm, input int tgt, input bit fin);
    if (k == 7) begin
      modelErr = 1'b1;
    end else begin
      expQ.push_back('{32'(modelNext), encodeRef(k, rs, rt, rd, sh, fn, imm, tgt)});
      modelNext++;
    end
    if (fin && !stopQueued) begin
      expQ.push_back('{32'(modelNext), STOP_REF});
      modelNext++;
      stopQueued = 1'b1;
    end
  endtask

  // Present one descriptor (optionally with finish) and hold it until accepted.
  task automatic applyStimulus(input int k, input int rs, input int rt, input int rd, input int sh,
                               input int fn, input int imm, input int tgt, input bit fin);
    int waited = 0;
    bus.in_valid  = 1'b1;
    bus.in_kind   = 3'(k);
    bus.in_rs     = 5'(rs);
    bus.in_rt     = 5'(rt);
    bus.in_rd     = 5'(rd);
    bus.in_shamt  = 5'(sh);
    bus.in_funct  = 6'(fn);
    bus.in_imm    = 16'(imm);
    bus.in_target = 26'(tgt);
    bus.finish    = fin;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: in_ready got %b, expected 1 within 20 cycles", bus.in_ready);
      driveIdle();
    end else begin
      @(posedge clk); #1;
      driveIdle();
      modelAccept(k, rs, rt, rd, sh, fn, imm, tgt, fin);
    end
  endtask

  task automatic sendFinish();
    bus.finish = 1'b1;
    @(posedge clk); #1;
    bus.finish = 1'b0;
    if (!stopQueued) begin
      expQ.push_back('{32'(modelNext), STOP_REF});
      modelNext++;
      stopQueued = 1'b1;
    end
  endtask

  task automatic expectWrite(input string name, input int expAddr, input logic [31:0] expData);
    int waited = 0;
    while (bus.we !== 1'b1 && waited < 10) begin
      @(posedge clk); #1;
      waited++;
    end
    if (bus.we !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_we: got %b, expected 1 within 10 cycles", name, bus.we);
    end else begin
      checkOutput({name, "_waddr"}, 32'(bus.waddr), 32'(expAddr));
      checkOutput({name, "_wdata"}, bus.wdata, expData);
      @(posedge clk); #1;
    end
  endtask

  task automatic doClear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    modelNext  = 0;
    modelErr   = 1'b0;
    stopQueued = 1'b0;
  endtask

  // Cycle-by-cycle comparison against the predictor, mid-cycle away from the clock edge.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 || clear === 1'b1) begin
        expQ.delete();
        written = 0;
        doneExp = 1'b0;
      end else begin
        checkOutput("cyc_count", 32'(count), 32'(written));
        checkOutput("cyc_full", 32'(full), 32'(written == DEPTH - 1));
        checkOutput("cyc_done", 32'(done), 32'(doneExp));
        checkOutput("cyc_err_illegal", 32'(err_illegal), 32'(modelErr));
        if (bus.we === 1'b1) begin
          if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL cyc_unexpected_we: got write %h at %0d, expected no write",
                     bus.wdata, bus.waddr);
          end else begin
            e = expQ.pop_front();
            checkOutput("cyc_waddr", 32'(bus.waddr), e.addr);
            checkOutput("cyc_wdata", bus.wdata, e.data);
            if (e.data == STOP_REF) doneExp = 1'b1;
          end
          written++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    clear = 1'b0;
    driveIdle();
    #7;
    checkOutput("rst_we", 32'(bus.we), 32'd0);
    checkOutput("rst_waddr", 32'(bus.waddr), 32'd0);
    checkOutput("rst_wdata", bus.wdata, 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err_illegal), 32'd0);
    checkOutput("rst_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;

    $display("[TB] ADDI, illegal kind, BEQ, J then fill to the STOP slot");
    applyStimulus(4, 0, 8, 0, 0, 0, 5, 0, 1'b0);
    expectWrite("addi", 0, 32'h20080005);
    checkOutput("addi_count", 32'(count), 32'd1);
    applyStimulus(7, 1, 1, 1, 1, 1, 1, 1, 1'b0);
    checkOutput("illegal_we", 32'(bus.we), 32'd0);
    checkOutput("illegal_err", 32'(err_illegal), 32'd1);
    checkOutput("illegal_count", 32'(count), 32'd1);
    applyStimulus(3, 1, 2, 0, 0, 0, 'hFFFE, 0, 1'b0);
    expectWrite("beq", 1, 32'h1022FFFE);
    applyStimulus(5, 0, 0, 0, 0, 0, 0, 'h3FFFFFF, 1'b0);
    expectWrite("jmax", 2, 32'h0BFFFFFF);
    checkOutput("full_flag", 32'(full), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_kind  = 3'd4;
    for (int i = 0; i < 3; i++) begin
      checkOutput("full_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("full_we", 32'(bus.we), 32'd0);
      @(posedge clk); #1;
    end
    driveIdle();
    sendFinish();
    expectWrite("full_stop", 3, 32'hFC000000);
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_done", 32'(done), 32'd1);
    bus.in_valid = 1'b1;
    bus.finish   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("done_ignore_we", 32'(bus.we), 32'd0);
      checkOutput("done_ready", 32'(bus.in_ready), 32'd0);
    end
    driveIdle();
    doClear();
    checkOutput("clr_done", 32'(done), 32'd0);
    checkOutput("clr_err", 32'(err_illegal), 32'd0);
    checkOutput("clr_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("clr_count", 32'(count), 32'd0);

    $display("[TB] RTYPE, LI, J sequence");
    applyStimulus(0, 8, 9, 10, 0, 'h20, 0, 0, 1'b0);
    expectWrite("rtype", 0, 32'h01095020);
    applyStimulus(6, 31, 3, 0, 0, 0, 'hBEEF, 0, 1'b0);
    expectWrite("li", 1, 32'h4403BEEF);
    applyStimulus(5, 0, 0, 0, 0, 0, 0, 'h10, 1'b0);
    expectWrite("j", 2, 32'h08000010);
    doClear();

    $display("[TB] SW with finish in the same cycle");
    applyStimulus(2, 29, 4, 0, 0, 0, 8, 0, 1'b1);
    expectWrite("sw", 0, 32'hAFA40008);
    expectWrite("sw_stop", 1, 32'hFC000000);
    checkOutput("sw_done", 32'(done), 32'd1);
    checkOutput("sw_count", 32'(count), 32'd2);
    doClear();

    $display("[TB] LW then reset during the write cycle");
    applyStimulus(1, 2, 7, 0, 0, 0, 'h0010, 0, 1'b0);
    checkOutput("lw_we", 32'(bus.we), 32'd1);
    checkOutput("lw_wdata", bus.wdata, 32'h8C470010);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rstmid_we", 32'(bus.we), 32'd0);
    checkOutput("rstmid_count", 32'(count), 32'd0);
    modelNext  = 0;
    modelErr   = 1'b0;
    stopQueued = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("rstmid_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rstmid_count_after", 32'(count), 32'd0);

    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("pending_writes", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
